dmem_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory request interface. It accepts one load or store at a time from the MEM stage over a valid/ready request channel. It models a configurable number of wait states, performs byte-enabled writes and sign/zero-extended reads on a word array, and returns the result over a valid/ready response channel. It replaces the zero-latency data memory path wherever multi-cycle memory timing must be exercised.

---
 rtl/dmem_pkg.sv | 88 ++++++++
 rtl/dmem_sram.sv | 34 +++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg : type encodings, FSM states and lane helpers            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  localparam int WCNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic logic access_err(input logic write, input logic [2:0] ltype,
                                      input logic [1:0] stype, input logic [1:0] a);
    logic e;
    e = 1'b0;
    if (write) begin
      case (stype)
        ST_SB:   e = 1'b0;
        ST_SH:   e = a[0];
        ST_SW:   e = |a;
        default: e = 1'b1;
      endcase
    end else begin
      case (ltype)
        LT_LB, LT_LBU: e = 1'b0;
        LT_LH, LT_LHU: e = a[0];
        LT_LW:         e = |a;
        default:       e = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] stype, input logic [1:0] a);
    logic [3:0] be;
    case (stype)
      ST_SB:   be = 4'b0001 << a;
      ST_SH:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] stype, input logic [31:0] d);
    logic [31:0] r;
    case (stype)
      ST_SB:   r = {4{d[7:0]}};
      ST_SH:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] ltype, input logic [1:0] a,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (ltype)
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'd0, b};
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'd0, h};
      LT_LW:   r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_sram : single-port word array, byte-enable write, reg. read  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module dmem_sram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end else if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_responder : wait-state data-memory responder, valid/ready    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [2:0]        i_req_load_type,
  input  logic [1:0]        i_req_store_type,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int WORD_W = ADDR_W - 2;
  localparam logic [WCNT_W-1:0] c_wait_load = (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

  state_t              r_state, w_next;
  logic [WCNT_W-1:0]   r_cnt;
  logic                r_init;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_ltype;
  logic [1:0]          r_stype;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic                w_accept, w_err, w_mem_we, w_mem_re;
  logic [WORD_W-1:0]   w_mem_addr;
  logic [31:0]         w_mem_q;

  assign w_accept = i_req_valid & o_req_ready;
  assign w_err    = access_err(r_write, r_ltype, r_stype, r_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (r_cnt == '0) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (i_rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE:   o_req_ready = r_init;
      S_ACCESS: w_mem_we    = r_write & ~w_err;
      S_RESP:   o_rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // The array read is launched on the edge entering ACCESS so its data is ready for the ACCESS edge.
  assign w_mem_re   = (w_next == S_ACCESS) && (r_state != S_ACCESS);
  assign w_mem_addr = (r_state == S_IDLE) ? i_req_addr[ADDR_W-1:2] : r_addr[ADDR_W-1:2];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= i_req_write;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
      r_ltype <= i_req_load_type;
      r_stype <= i_req_store_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init  <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_init <= 1'b1;
      if (w_accept) r_cnt <= c_wait_load;
      else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_ACCESS) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_write) ? '0 : load_extract(r_ltype, r_addr[1:0], w_mem_q);
      end
    end
  end

  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  dmem_sram #(.AW(WORD_W)) u_sram (
    .clk     (clk),
    .i_re    (w_mem_re),
    .i_we    (w_mem_we),
    .i_be    (store_be(r_stype, r_addr[1:0])),
    .i_addr  (w_mem_addr),
    .i_wdata (store_data(r_stype, r_wdata)),
    .o_rdata (w_mem_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_responder : vector table, corner sequences, random model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int AW = 10;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_write = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [31:0]   i_req_wdata = '0;
  logic [2:0]    i_req_load_type = '0;
  logic [1:0]    i_req_store_type = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem_m [0:(1<<AW)-1];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_write      (i_req_write),
    .i_req_addr       (i_req_addr),
    .i_req_wdata      (i_req_wdata),
    .i_req_load_type  (i_req_load_type),
    .i_req_store_type (i_req_store_type),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_rsp_err        (o_rsp_err)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [2:0]    lt;
    logic [1:0]    st;
    logic [31:0]   er;
    logic          ee;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural memory: byte array, access size derived from the type code.
  function automatic void model(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                                input logic [2:0] lt, input logic [1:0] st,
                                output logic [31:0] rd, output logic e);
    int sz;
    logic [31:0] val;
    e = 1'b0;
    rd = '0;
    if (w) begin
      if (st == 2'd3) e = 1'b1;
      else begin
        sz = 1 << st;
        if (int'(a) % sz != 0) e = 1'b1;
        else for (int i = 0; i < sz; i++) mem_m[int'(a) + i] = d[8*i +: 8];
      end
    end else begin
      if (lt == 3'd3 || lt > 3'd5) e = 1'b1;
      else begin
        sz = 1 << lt[1:0];
        if (int'(a) % sz != 0) e = 1'b1;
        else begin
          val = '0;
          for (int i = 0; i < sz; i++) val[8*i +: 8] = mem_m[int'(a) + i];
          if (!lt[2] && sz < 4 && val[sz*8-1]) val = val | (32'hFFFF_FFFF << (sz*8));
          rd = val;
        end
      end
    end
  endfunction

  // One full transaction; optionally holds the response and pokes a request while held.
  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [2:0] lt, input logic [1:0] st, input int hold, input bit poke,
                     output logic [31:0] rd, output logic e);
    int lat;
    for (int n = 0; n < 20 && !o_req_ready; n++) begin
      @(posedge clk); #1;
    end
    chk("req_ready_before_req", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_write = w; i_req_addr = a; i_req_wdata = d;
    i_req_load_type = lt; i_req_store_type = st;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", lat, WS + 1);
    rd = o_rsp_rdata;
    e  = o_rsp_err;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = a; i_req_wdata = 32'h0;
        i_req_store_type = 2'b10;
      end
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      chk("hold_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", o_rsp_rdata, rd);
      chk("hold_req_ready", {31'd0, o_req_ready}, 32'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    chk("req_ready_after_hs", {31'd0, o_req_ready}, 32'd1);
  endtask

  task automatic run_model(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [2:0] lt, input logic [1:0] st, input int hold,
                           input string name);
    logic [31:0] rd, mrd;
    logic        e, me;
    txn(w, a, d, lt, st, hold, 1'b0, rd, e);
    model(w, a, d, lt, st, mrd, me);
    chk({name, "_rdata"}, rd, mrd);
    chk({name, "_err"}, {31'd0, e}, {31'd0, me});
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    logic        e;

    #2;
    chk("reset_req_ready", {31'd0, o_req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("reset_rsp_err",   {31'd0, o_rsp_err}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_first_edge", {31'd0, o_req_ready}, 32'd1);

    // Preload words 0..15 with 0x11111111*(w+1).
    for (int w = 0; w < 16; w++) run_model(1'b1, AW'(4*w), 32'h1111_1111 * (w + 1), 3'd0, 2'd2, 0, "preload");

    vecs.push_back('{1'b1, 10'h010, 32'hDEAD_BEEF, 3'd0, 2'd2, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 10'h010, 32'h0,         3'd2, 2'd0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 10'h013, 32'h0,         3'd0, 2'd0, 32'hFFFF_FFDE, 1'b0});
    vecs.push_back('{1'b0, 10'h013, 32'h0,         3'd4, 2'd0, 32'h0000_00DE, 1'b0});
    vecs.push_back('{1'b0, 10'h012, 32'h0,         3'd1, 2'd0, 32'hFFFF_DEAD, 1'b0});
    vecs.push_back('{1'b0, 10'h010, 32'h0,         3'd5, 2'd0, 32'h0000_BEEF, 1'b0});
    vecs.push_back('{1'b1, 10'h011, 32'h0000_0055, 3'd0, 2'd0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 10'h010, 32'h0,         3'd2, 2'd0, 32'hDEAD_55EF, 1'b0});
    vecs.push_back('{1'b0, 10'h012, 32'h0,         3'd2, 2'd0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 10'h021, 32'h0000_1234, 3'd0, 2'd1, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 10'h020, 32'h0,         3'd2, 2'd0, 32'h9999_9999, 1'b0});
    vecs.push_back('{1'b0, 10'h000, 32'h0,         3'd3, 2'd0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 10'h020, 32'hFFFF_FFFF, 3'd0, 2'd3, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 10'h020, 32'h0,         3'd2, 2'd0, 32'h9999_9999, 1'b0});

    foreach (vecs[i]) begin
      logic [31:0] mrd;
      logic        me;
      txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].lt, vecs[i].st, 0, 1'b0, rd, e);
      model(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].lt, vecs[i].st, mrd, me);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].er);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].ee});
    end

    // Response held for 5 cycles with a stray store poked in; it must not land.
    txn(1'b0, 10'h010, 32'h0, 3'd2, 2'd0, 5, 1'b1, rd, e);
    chk("held_rdata", rd, 32'hDEAD_55EF);
    txn(1'b0, 10'h010, 32'h0, 3'd2, 2'd0, 0, 1'b0, rd, e);
    chk("after_poke_rdata", rd, 32'hDEAD_55EF);

    // Reset during WAIT of a store: dropped.
    for (int n = 0; n < 20 && !o_req_ready; n++) begin
      @(posedge clk); #1;
    end
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 10'h030; i_req_wdata = 32'hA5A5_A5A5;
    i_req_store_type = 2'd2;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, o_req_ready}, 32'd0);
    chk("rst_mid_rsp_rdata", o_rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", {31'd0, o_req_ready}, 32'd1);
    txn(1'b0, 10'h030, 32'h0, 3'd2, 2'd0, 0, 1'b0, rd, e);
    chk("dropped_store_rdata", rd, 32'hDDDD_DDDD);

    // Random traffic over the preloaded region against the byte model.
    for (int k = 0; k < 80; k++) begin
      run_model(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom,
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
